// File: rtl/pearson_hash_scheduler.sv
// Round-robin scheduler that shares a single Pearson hash engine among
// NUM_REQ requesters. Each job: latch the winner's message, hold the engine
// in reset for CLEAR_CYCLES, run it until it finishes (or times out), then
// pulse done to the owner with the hash (8'hFF plus result_error on timeout).
//
// Handshake: req[i] is a level the requester holds until it sees grant[i].
// grant[i] is a one-cycle pulse on the cycle the message is sampled. done[i]
// is a one-cycle pulse on the cycle result_hash/result_error are valid for i.
// Requests are only looked at in IDLE; nothing is queued.
module pearson_hash_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int CLEAR_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [64*NUM_REQ-1:0]   req_message,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      done,
  output logic [7:0]              result_hash,
  output logic                    result_error,
  output logic                    busy,
  output logic                    eng_reset_n,
  output logic                    eng_enable,
  output logic [63:0]             eng_message,
  input  logic [7:0]              eng_hash,
  input  logic                    eng_finished,
  output logic [1:0]              dbg_state
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int RW = $clog2(TIMEOUT_CYCLES);
  localparam int CW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [63:0]     msg_q, msg_d;
  logic [CW-1:0]   clr_cnt_q, clr_cnt_d;
  logic [RW-1:0]   run_cnt_q, run_cnt_d;
  logic [7:0]      hash_q, hash_d;
  logic            err_q, err_d;

  logic [PW-1:0]   win;
  logic [PW-1:0]   win_next;

  // First set request bit at or after ptr, wrapping around.
  function automatic logic [PW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                            input logic [PW-1:0] ptr);
    logic [PW-1:0] w;
    logic          found;
    int            idx;
    w     = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && r[idx]) begin
        found = 1'b1;
        w     = PW'(idx);
      end
    end
    return w;
  endfunction

  // Arbitration winner and the pointer value that follows it.
  always_comb begin
    win      = rr_pick(req, rr_ptr_q);
    win_next = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
  end

  // Next-state logic and outputs; reset forces every pulse/engine output low.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    msg_d       = msg_q;
    clr_cnt_d   = clr_cnt_q;
    run_cnt_d   = run_cnt_q;
    hash_d      = hash_q;
    err_d       = err_q;
    grant       = '0;
    done        = '0;
    busy        = 1'b1;
    eng_reset_n = 1'b1;
    eng_enable  = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (|req) begin
          grant[win] = 1'b1;
          msg_d      = req_message[int'(win)*64 +: 64];
          owner_d    = win;
          rr_ptr_d   = win_next;
          clr_cnt_d  = '0;
          state_d    = S_CLEAR;
        end
      end
      S_CLEAR: begin
        // Engine held in reset; a stale finished flag is ignored here.
        eng_reset_n = 1'b0;
        if (clr_cnt_q == CW'(CLEAR_CYCLES - 1)) begin
          run_cnt_d = '0;
          state_d   = S_RUN;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        eng_enable = 1'b1;
        run_cnt_d  = run_cnt_q + 1'b1;
        if (eng_finished) begin
          hash_d  = eng_hash;
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (run_cnt_q == RW'(TIMEOUT_CYCLES - 1)) begin
          hash_d  = 8'hFF;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done[owner_q] = 1'b1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (reset) begin
      grant       = '0;
      done        = '0;
      busy        = 1'b0;
      eng_reset_n = 1'b0;
      eng_enable  = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      msg_q     <= '0;
      clr_cnt_q <= '0;
      run_cnt_q <= '0;
      hash_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      msg_q     <= msg_d;
      clr_cnt_q <= clr_cnt_d;
      run_cnt_q <= run_cnt_d;
      hash_q    <= hash_d;
      err_q     <= err_d;
    end
  end

  assign eng_message  = msg_q;
  assign result_hash  = hash_q;
  assign result_error = err_q;
  assign dbg_state    = state_q;

endmodule
